// File: rtl/power_seq_ctrl.sv
// Power sequencing controller: brings up the R&T rail, then the a1/d1 switcher sync clocks, and latches faults.
// Optional feature macro PWR_SYNC_INTERLEAVE_EN: drive pwr_sync_d1 180 degrees out of phase with pwr_sync_a1.
module power_seq_ctrl #(
    parameter int unsigned SYNC_DIV   = 25,
    parameter int unsigned SETTLE_CYC = 1000,
    parameter int unsigned PG_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       pg_rt,
    input  logic       pg_a1,
    input  logic       pg_d1,
    input  logic       fault_clr,
    output logic       power_rt_on,
    output logic       pwr_sync_a1,
    output logic       pwr_sync_d1,
    output logic       pwr_ready,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RT_ON   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SYNC_ON = 3'd3,
        ST_RUN     = 3'd4,
        ST_SHUTDN  = 3'd5,
        ST_FAULT   = 3'd6
    } state_e;

    localparam int unsigned TMR_W = 24;
    localparam int unsigned DIV_W = 16;

    localparam logic [TMR_W-1:0] PG_LAST     = TMR_W'(PG_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 32'd1);
    localparam logic [TMR_W-1:0] TMR_MAX     = {TMR_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SYNC_DIV - 32'd1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_RT   = 2'b01;
    localparam logic [1:0] CODE_SW   = 2'b10;
    localparam logic [1:0] CODE_LOST = 2'b11;

    function automatic logic sync_active(input state_e s);
        return (s == ST_SYNC_ON) || (s == ST_RUN);
    endfunction

    function automatic logic rail_on(input state_e s);
        return (s == ST_RT_ON) || (s == ST_SETTLE) || (s == ST_SYNC_ON) ||
               (s == ST_RUN) || (s == ST_SHUTDN);
    endfunction

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [1:0]       code_q, code_d;
    logic             rt_on_q, rt_on_d;
    logic             sync_d1_q, sync_d1_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             sync_run_now_s;
    logic             sync_run_next_s;

    // Next-state and fault-cause selection; pwr_req=0 always wins over power-good/timeout events.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_OFF: begin
                if (pwr_req) begin
                    state_d = ST_RT_ON;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_RT_ON: begin
                if (!pwr_req) begin
                    state_d = ST_SHUTDN;
                end else if (pg_rt) begin
                    state_d = ST_SETTLE;
                end else if (timer_q == PG_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_RT;
                end else begin
                    state_d = ST_RT_ON;
                end
            end
            ST_SETTLE: begin
                if (!pwr_req) begin
                    state_d = ST_SHUTDN;
                end else if (!pg_rt) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_RT;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = ST_SYNC_ON;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SYNC_ON: begin
                if (!pwr_req) begin
                    state_d = ST_SHUTDN;
                end else if (!pg_rt) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_LOST;
                end else if (pg_a1 && pg_d1) begin
                    state_d = ST_RUN;
                end else if (timer_q == PG_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_SW;
                end else begin
                    state_d = ST_SYNC_ON;
                end
            end
            ST_RUN: begin
                if (!pwr_req) begin
                    state_d = ST_SHUTDN;
                end else if (!(pg_rt && pg_a1 && pg_d1)) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_LOST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SHUTDN: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_SHUTDN;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !pwr_req) begin
                    state_d = ST_OFF;
                    code_d  = CODE_NONE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_OFF;
                code_d  = CODE_NONE;
            end
        endcase
    end

    // Phase timer: cleared on every state change, saturates instead of wrapping.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = {TMR_W{1'b0}};
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end
    end

    // Sync divider: restarts from zero/low on SYNC_ON entry, idle outside SYNC_ON and RUN.
    always_comb begin
        sync_run_now_s  = sync_active(state_q);
        sync_run_next_s = sync_active(state_d);
        if (sync_run_now_s && sync_run_next_s) begin
            if (div_q >= DIV_LAST) begin
                div_d   = {DIV_W{1'b0}};
                phase_d = ~phase_q;
            end else begin
                div_d   = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
                phase_d = phase_q;
            end
        end else begin
            div_d   = {DIV_W{1'b0}};
            phase_d = 1'b0;
        end
    end

    // Output decode from the next state so every output is a flop aligned with state.
    always_comb begin
        rt_on_d = rail_on(state_d);
        ready_d = (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
`ifdef PWR_SYNC_INTERLEAVE_EN
        if (sync_run_next_s) begin
            sync_d1_d = ~phase_d;
        end else begin
            sync_d1_d = 1'b0;
        end
`else
        sync_d1_d = phase_d;
`endif
    end

    // State, counters and output registers; reset drops every enable with no clock needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_OFF;
            timer_q   <= {TMR_W{1'b0}};
            div_q     <= {DIV_W{1'b0}};
            phase_q   <= 1'b0;
            code_q    <= CODE_NONE;
            rt_on_q   <= 1'b0;
            sync_d1_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            code_q    <= code_d;
            rt_on_q   <= rt_on_d;
            sync_d1_q <= sync_d1_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign power_rt_on = rt_on_q;
    assign pwr_sync_a1 = phase_q;
    assign pwr_sync_d1 = sync_d1_q;
    assign pwr_ready   = ready_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign state       = state_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Scoreboard bench for power_seq_ctrl: a timestamp-based reference model queues expected outputs, a monitor compares.
module tb_power_seq_ctrl;

    localparam int SYNC_DIV   = 2;
    localparam int SETTLE_CYC = 4;
    localparam int PG_TIMEOUT = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwr_req = 1'b0;
    logic       pg_rt = 1'b0;
    logic       pg_a1 = 1'b0;
    logic       pg_d1 = 1'b0;
    logic       fault_clr = 1'b0;
    logic       power_rt_on;
    logic       pwr_sync_a1;
    logic       pwr_sync_d1;
    logic       pwr_ready;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state_o;

    typedef struct packed {
        logic       rt_on;
        logic       a1;
        logic       d1;
        logic       ready;
        logic       flt;
        logic [1:0] code;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp;
    int   tests = 0;
    int   fails = 0;

    // Reference model: phase number, edge count at phase entry, edge count at sync start.
    int m_st, m_code, m_n, m_entry, m_sync_entry;

    power_seq_ctrl #(
        .SYNC_DIV  (SYNC_DIV),
        .SETTLE_CYC(SETTLE_CYC),
        .PG_TIMEOUT(PG_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwr_req    (pwr_req),
        .pg_rt      (pg_rt),
        .pg_a1      (pg_a1),
        .pg_d1      (pg_d1),
        .fault_clr  (fault_clr),
        .power_rt_on(power_rt_on),
        .pwr_sync_a1(pwr_sync_a1),
        .pwr_sync_d1(pwr_sync_d1),
        .pwr_ready  (pwr_ready),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        return {power_rt_on, pwr_sync_a1, pwr_sync_d1, pwr_ready, fault, fault_code, state_o};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s t=%0t actual=%b required=%b (rt_on,a1,d1,ready,fault,code,state)",
                     name, $time, act, req);
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        int   k;
        o = '0;
        o.st    = 3'(m_st);
        o.code  = 2'(m_code);
        o.rt_on = (m_st >= 1) && (m_st <= 5);
        o.ready = (m_st == 4);
        o.flt   = (m_st == 6);
        if (m_st == 3 || m_st == 4) begin
            k    = m_n - m_sync_entry;
            o.a1 = ((k / SYNC_DIV) % 2) == 1;
`ifdef PWR_SYNC_INTERLEAVE_EN
            o.d1 = !o.a1;
`else
            o.d1 = o.a1;
`endif
        end
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_code = 0; m_n = 0; m_entry = 0; m_sync_entry = 0;
    endtask

    // Phases: 0 OFF, 1 RT_ON, 2 SETTLE, 3 SYNC_ON, 4 RUN, 5 SHUTDN, 6 FAULT.
    task automatic model_step(input logic req, input logic prt, input logic pa, input logic pd,
                              input logic clr);
        int el, nxt, ncode;
        el    = m_n - m_entry;
        nxt   = m_st;
        ncode = m_code;
        case (m_st)
            0: if (req) nxt = 1;
            1: if (!req) nxt = 5;
               else if (prt) nxt = 2;
               else if (el == PG_TIMEOUT - 1) begin nxt = 6; ncode = 1; end
            2: if (!req) nxt = 5;
               else if (!prt) begin nxt = 6; ncode = 1; end
               else if (el == SETTLE_CYC - 1) nxt = 3;
            3: if (!req) nxt = 5;
               else if (!prt) begin nxt = 6; ncode = 3; end
               else if (pa && pd) nxt = 4;
               else if (el == PG_TIMEOUT - 1) begin nxt = 6; ncode = 2; end
            4: if (!req) nxt = 5;
               else if (!(prt && pa && pd)) begin nxt = 6; ncode = 3; end
            5: if (el == SETTLE_CYC - 1) nxt = 0;
            6: if (clr && !req) begin nxt = 0; ncode = 0; end
            default: nxt = 0;
        endcase
        m_n++;
        if (nxt != m_st) begin
            m_entry = m_n;
            if (nxt == 3) m_sync_entry = m_n;
        end
        m_st   = nxt;
        m_code = ncode;
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input logic req, input logic prt, input logic pa, input logic pd,
                        input logic clr);
        pwr_req = req; pg_rt = prt; pg_a1 = pa; pg_d1 = pd; fault_clr = clr;
        model_step(req, prt, pa, pd, clr);
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic to_off();
        repeat (SETTLE_CYC + 3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic power_up(input int d_rt, input int d_sw, input int n_run);
        repeat (d_rt) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (d_sw) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (n_run) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic end_shutdown();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (SETTLE_CYC) step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic end_pg_loss();
        int which;
        which = $urandom_range(0, 2);
        step(1'b1, 1'(which != 0), 1'(which != 1), 1'(which != 2), 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scen_async_reset();
        obs_t zero;
        zero = '0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (SETTLE_CYC + 3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_obs("async_reset_mid_sync", dut_obs(), zero);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_obs("held_in_reset", dut_obs(), zero);
        rst = 1'b1;
        model_reset();
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        to_off();
    endtask

    task automatic scen_chaos();
        repeat (30) step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) != 0),
                         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                         1'($urandom_range(0, 5) == 0));
        to_off();
    endtask

    // Scoreboard monitor: one expected vector per clock, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check_obs("outputs", dut_obs(), mon_exp);
        end
    end

    initial begin
        obs_t zero;
        int   sc;
        zero = '0;
        model_reset();
        #2 rst = 1'b0;
        #2 check_obs("reset_state", dut_obs(), zero);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed: nominal bring-up and shutdown, rail timeout, power-good loss, reset mid-sync.
        power_up(10, 6, 10);
        end_shutdown();
        power_up(PG_TIMEOUT + 3, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        to_off();
        power_up(3, SETTLE_CYC + 2, 6);
        end_pg_loss();
        power_up(2, PG_TIMEOUT + SETTLE_CYC + 3, 0);
        to_off();
        scen_async_reset();

        for (int it = 0; it < 50; it++) begin
            sc = $urandom_range(0, 3);
            case (sc)
                0: begin
                    power_up($urandom_range(1, PG_TIMEOUT - 1), $urandom_range(1, 12),
                             $urandom_range(0, 10));
                    end_shutdown();
                end
                1: begin
                    power_up($urandom_range(1, PG_TIMEOUT - 1),
                             $urandom_range(SETTLE_CYC + 1, SETTLE_CYC + PG_TIMEOUT + 2),
                             $urandom_range(1, 6));
                    end_pg_loss();
                end
                2: scen_chaos();
                default: begin
                    power_up($urandom_range(1, PG_TIMEOUT + 4), 0, 0);
                    to_off();
                end
            endcase
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
